button_debouncer: RTL

Conditions a raw, bouncy push-button or switch level into a clean, single-clock-domain level plus one-cycle edge pulses. Sits directly upstream of the DFF/register stages. btn_out drives their D input and rise_pulse/fall_pulse drive their enables. Holding time is set by a counter-based FSM, so a glitch shorter than STABLE_CYCLES never reaches downstream flops.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/sync_2ff.sv | 25 ++
 rtl/button_debouncer.sv | 107 ++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer: FSM state encodings and the
// default hold time (10 ms at 50 MHz).
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b11,
    WAIT_LOW    = 2'b10
  } state_e;

  localparam int unsigned DEF_STABLE_CYCLES = 500000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reusable by any
// pin-facing block. Synchronous active-high reset clears both flops.
module sync_2ff (
  input  logic Clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge Clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Counter-based debouncer: a new level must persist STABLE_CYCLES sampled edges
// before btn_out follows it. Define DEBOUNCE_SYNC_EN to add a 2-flop input synchronizer.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic Clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned CNT_WIDTH = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .Clk (Clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s)
  );
`else
  assign s = btn_in;
`endif

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   btn_q, btn_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // An opposite sample in a WAIT state drops straight back: no partial credit.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      STABLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = STABLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
      end
    endcase
  end

  // Outputs are registered, so they are derived from the transition being taken.
  always_comb begin
    btn_d  = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
    rise_d = (state_q == WAIT_HIGH) && (state_d == STABLE_HIGH);
    fall_d = (state_q == WAIT_LOW)  && (state_d == STABLE_LOW);
  end

  assign btn_out    = btn_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule
